// File: rtl/rsi_pkg.sv
// Shared types and constants for the RSI evaluation scheduler.
package rsi_pkg;
  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 32;
  localparam int RSI_MAX = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/rsi_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant.
module rsi_rr_arb
  import rsi_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] last_grant,
  output logic [NCH-1:0]         grant
);
  localparam int CW = $clog2(NCH);

  logic [CW:0] cand;
  logic        found;

  // Scan last_grant+1 .. last_grant+NCH, wrapping modulo NCH.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = {1'b0, last_grant} + (CW+1)'(i);
      if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
      if (!found && req[cand[CW-1:0]]) begin
        grant[cand[CW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rsi_sched.sv
// Round-robin scheduler sharing one fixed-latency RSI evaluator among NCH channels.
module rsi_sched
  import rsi_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  parameter int LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH*W-1:0]       req_rsi,
  output logic [NCH-1:0]         req_ready,
  output logic [W-1:0]           eval_rsi,
  input  logic                   eval_out1,
  input  logic                   eval_out2,
  output logic                   res_valid,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic                   res_out1,
  output logic                   res_out2,
  output logic                   res_err,
  output logic                   busy
);
  localparam int           CW      = $clog2(NCH);
  localparam logic [W-1:0] RSI_LIM = W'(RSI_MAX);
  localparam logic [3:0]   LAT_LD  = 4'(LAT);

  state_t        state, state_nxt;
  logic [CW-1:0] last_grant;
  logic [3:0]    cnt;
  logic [NCH-1:0] grant;
  logic [CW-1:0] gnt_idx;
  logic [W-1:0]  gnt_rsi;
  logic          xfer;
  logic          rsi_bad;

  rsi_rr_arb #(.NCH(NCH)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_rsi = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant[c]) begin
        gnt_idx = CW'(c);
        gnt_rsi = req_rsi[c*W +: W];
      end
    end
  end

  assign rsi_bad = (gnt_rsi > RSI_LIM);

  // Grants are only offered from IDLE and never while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    xfer      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = rst_n ? grant : '0;
        xfer      = |(req_valid & req_ready);
        if (xfer) state_nxt = rsi_bad ? ST_REPORT : ST_WAIT;
      end
      ST_WAIT:   if (cnt == 4'd1) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Result fields change only on the edge entering REPORT, so they hold between reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= CW'(NCH-1);
      cnt        <= '0;
      eval_rsi   <= '0;
      res_ch     <= '0;
      res_out1   <= 1'b0;
      res_out2   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        last_grant <= gnt_idx;
        if (rsi_bad) begin
          res_ch   <= gnt_idx;
          res_err  <= 1'b1;
          res_out1 <= 1'b0;
          res_out2 <= 1'b0;
        end else begin
          eval_rsi <= gnt_rsi;
          cnt      <= LAT_LD;
        end
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          res_ch   <= last_grant;
          res_out1 <= eval_out1;
          res_out2 <= eval_out2;
          res_err  <= 1'b0;
        end
      end
    end
  end

  assign res_valid = (state == ST_REPORT);
  assign busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_rsi_sched.sv
// Self-checking bench for rsi_sched: directed scenarios plus randomized traffic vs a transaction model.
module tb_rsi_sched;
  localparam int NCH  = 4;
  localparam int W    = 32;
  localparam int LAT0 = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   req_valid = '0;
  logic [NCH*W-1:0] req_rsi = '0;
  logic [NCH-1:0]   req_ready;
  logic [W-1:0]     eval_rsi;
  logic             eval_out1, eval_out2;
  logic             res_valid, res_out1, res_out2, res_err, busy;
  logic [1:0]       res_ch;

  logic [NCH-1:0]   req_valid_l1 = '0;
  logic [NCH*W-1:0] req_rsi_l1 = '0;
  logic [NCH-1:0]   req_ready_l1;
  logic [W-1:0]     eval_rsi_l1;
  logic             eval_out1_l1, eval_out2_l1;
  logic             res_valid_l1, res_out1_l1, res_out2_l1, res_err_l1, busy_l1;
  logic [1:0]       res_ch_l1;

  always #5 clk = ~clk;

  rsi_sched #(.NCH(NCH), .W(W), .LAT(LAT0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rsi(req_rsi),
    .req_ready(req_ready), .eval_rsi(eval_rsi), .eval_out1(eval_out1),
    .eval_out2(eval_out2), .res_valid(res_valid), .res_ch(res_ch),
    .res_out1(res_out1), .res_out2(res_out2), .res_err(res_err), .busy(busy)
  );

  rsi_sched #(.NCH(NCH), .W(W), .LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_l1), .req_rsi(req_rsi_l1),
    .req_ready(req_ready_l1), .eval_rsi(eval_rsi_l1), .eval_out1(eval_out1_l1),
    .eval_out2(eval_out2_l1), .res_valid(res_valid_l1), .res_ch(res_ch_l1),
    .res_out1(res_out1_l1), .res_out2(res_out2_l1), .res_err(res_err_l1), .busy(busy_l1)
  );

  // Evaluator: outputs valid in the LAT-th cycle after eval_rsi loads, i.e. LAT-1 register stages.
  logic [W-1:0] ev_d;
  always @(posedge clk) ev_d <= eval_rsi;
  assign eval_out1    = (ev_d < 30);
  assign eval_out2    = (ev_d > 70);
  assign eval_out1_l1 = (eval_rsi_l1 < 30);
  assign eval_out2_l1 = (eval_rsi_l1 > 70);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state
  int           m_last = NCH - 1;
  logic [W-1:0] m_eval = '0;
  int           p_ch = 0;
  bit           p_o1 = 1'b0, p_o2 = 1'b0, p_err = 1'b0;
  int           got_ch, gnt_cyc, prev_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NCH-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = (last + k) % NCH;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_eval_rsi"}, eval_rsi, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_ch"}, res_ch, 0);
    check({tag, "_res_out1"}, res_out1, 0);
    check({tag, "_res_out2"}, res_out2, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One request from grant through report; returns in the following IDLE cycle.
  task automatic txn(input bit drop);
    int n, ch;
    logic [W-1:0] rsi;
    logic [NCH-1:0] oh;
    bit bad, e1, e2;
    #1;
    n = 0;
    while (req_ready == '0 && n < 60) begin @(negedge clk); #1; n++; end
    ch = model_pick(req_valid, m_last);
    oh = '0;
    oh[ch] = 1'b1;
    check("grant", req_ready, oh);
    got_ch  = ch;
    gnt_cyc = cyc;
    rsi = req_rsi[ch*W +: W];
    bad = (rsi > 100);
    e1  = !bad && (rsi < 30);
    e2  = !bad && (rsi > 70);
    if (!bad) m_eval = rsi;
    m_last = ch;
    @(negedge clk); #1;
    if (drop) req_valid[ch] = 1'b0;
    check("busy", busy, 1);
    check("ready_off", req_ready, 0);
    check("eval_rsi", eval_rsi, m_eval);
    if (!bad) begin
      check("hold_ch", res_ch, p_ch);
      check("hold_out1", res_out1, p_o1);
      check("hold_out2", res_out2, p_o2);
      check("hold_err", res_err, p_err);
    end
    n = 1;
    while (!res_valid && n < 40) begin @(negedge clk); #1; n++; end
    check("latency", n, bad ? 1 : LAT0 + 1);
    check("res_ch", res_ch, ch);
    check("res_out1", res_out1, e1);
    check("res_out2", res_out2, e2);
    check("res_err", res_err, bad);
    check("ready_report", req_ready, 0);
    p_ch = ch; p_o1 = e1; p_o2 = e2; p_err = bad;
    @(negedge clk); #1;
    check("res_once", res_valid, 0);
    check("res_hold", res_ch, ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    logic [NCH-1:0] mk;

    // Reset with all channels requesting: everything must stay quiet
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = '1;
    req_rsi = {32'd90, 32'd80, 32'd50, 32'd10};
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");

    // All four channels from reset: grants 0,1,2,3 every LAT+2 cycles
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      txn(1'b1);
      check("order4", got_ch, k);
      if (k > 0) check("gap4", gnt_cyc - prev_cyc, LAT0 + 2);
      prev_cyc = gnt_cyc;
    end

    // Single request ch2 rsi=25
    req_rsi[2*W +: W] = 32'd25;
    req_valid = 4'b0100;
    txn(1'b1);
    check("single_ch", got_ch, 2);

    // Range error ch1 rsi=101, then boundaries 100 and 0
    req_rsi[1*W +: W] = 32'd101;
    req_valid = 4'b0010;
    txn(1'b1);
    req_rsi[0*W +: W] = 32'd100;
    req_valid = 4'b0001;
    txn(1'b1);
    req_rsi[3*W +: W] = 32'd0;
    req_valid = 4'b1000;
    txn(1'b1);

    // Fairness: ch0 and ch3 continuously valid for 40 cycles
    req_rsi[0*W +: W] = 32'd60;
    req_rsi[3*W +: W] = 32'd5;
    req_valid = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      txn(1'b0);
      check("fair_ch", got_ch, (k % 2 == 0) ? 0 : 3);
      if (k > 0) check("fair_gap", gnt_cyc - prev_cyc, LAT0 + 2);
      prev_cyc = gnt_cyc;
    end
    req_valid = '0;

    // Reset during WAIT discards the request
    req_rsi[2*W +: W] = 32'd40;
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    check("rst_grant", req_ready, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_zero("midwait");
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NCH - 1; m_eval = '0;
    p_ch = 0; p_o1 = 1'b0; p_o2 = 1'b0; p_err = 1'b0;
    saw = 1'b0;
    repeat (LAT0 + 4) begin @(negedge clk); #1; if (res_valid) saw = 1'b1; end
    check("no_res_after_rst", saw, 0);
    req_valid = 4'b0101;
    txn(1'b1);
    check("after_rst_ch", got_ch, 0);
    req_valid = '0;

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      mk = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int c = 0; c < NCH; c++) req_rsi[c*W +: W] = W'($urandom_range(0, 127));
      req_valid = mk;
      txn(1'b1);
    end
    req_valid = '0;

    // LAT=1 instance: rsi=0 on ch0 reports at T+2
    req_rsi_l1[0 +: W] = 32'd0;
    req_valid_l1 = 4'b0001;
    #1;
    n = 0;
    while (req_ready_l1 == '0 && n < 20) begin @(negedge clk); #1; n++; end
    check("l1_grant", req_ready_l1, 4'b0001);
    @(negedge clk); #1;
    req_valid_l1 = '0;
    n = 1;
    while (!res_valid_l1 && n < 20) begin @(negedge clk); #1; n++; end
    check("l1_latency", n, 2);
    check("l1_res_ch", res_ch_l1, 0);
    check("l1_out1", res_out1_l1, 1);
    check("l1_out2", res_out2_l1, 0);
    check("l1_err", res_err_l1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rsi_sched.md
RSI_SCHED -- requirements
Module: rsi_sched

Interface
REQ-001 Parameter NCH, default 4: number of requesting symbol channels.
REQ-002 Parameter W, default 32: RSI value width.
REQ-003 Parameter LAT, default 2, legal range 1..15: evaluator latency in cycles from eval_rsi stable to eval_out1/eval_out2 valid.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NCH  per-channel request pending.
REQ-008 req_rsi  input  NCH*W  per-channel RSI value; channel c occupies bits [c*W +: W].
REQ-009 req_ready  output  NCH  one-hot grant; the request transfers when req_valid[c] and req_ready[c] are both high on a rising edge.
REQ-010 eval_rsi  output  W  registered value driven to the shared RSI evaluator.
REQ-011 eval_out1, eval_out2  input  1 each  evaluator outputs.
REQ-012 res_valid  output  1  one-cycle result strobe.
REQ-013 res_ch  output  clog2(NCH)  channel owning the result.
REQ-014 res_out1, res_out2, res_err  output  1 each  captured evaluator outputs and range-error flag.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, REPORT.
REQ-017 IDLE: if any req_valid bit is high, assert req_ready for exactly one channel, chosen round-robin starting at last_grant+1 modulo NCH.
REQ-018 IDLE: a channel whose req_valid is low in that cycle SHALL never be granted; if no bit is high, req_ready = 0 and the FSM stays in IDLE.
REQ-019 On transfer with req_rsi <= 100: load eval_rsi, set last_grant = c, load the counter with LAT, and go to WAIT.
REQ-020 On transfer with req_rsi > 100: eval_rsi unchanged, res_err = 1, res_out1 = res_out2 = 0, go directly to REPORT.
REQ-021 WAIT: req_ready = 0 and eval_rsi is held stable; the counter decrements each cycle.
REQ-022 WAIT exit: in the cycle the counter equals 1, eval_out1/eval_out2 are captured into res_out1/res_out2, res_err = 0, and the FSM goes to REPORT.
REQ-023 REPORT: res_valid = 1 for exactly one cycle with res_ch = granted channel, then IDLE; req_ready = 0 in REPORT.
REQ-024 Latency: a transfer on edge T SHALL produce res_valid in cycle T+LAT+1 (valid range) or T+1 (error).
REQ-025 Throughput: at most one transfer per LAT+2 cycles; a single channel continuously valid SHALL be served every LAT+2 cycles.
REQ-026 res_out1, res_out2, res_err and res_ch SHALL hold their values until the next REPORT.
REQ-027 last_grant SHALL wrap from NCH-1 to 0.
REQ-028 An error request SHALL advance last_grant the same as a valid request.

Reset
REQ-029 Asserting rst_n low SHALL force: state IDLE, last_grant = NCH-1 (so channel 0 has first priority), counter 0, eval_rsi 0, all outputs 0.
REQ-030 Reset asserted mid-WAIT or mid-REPORT SHALL discard the in-flight request; no res_valid is produced for it.
REQ-031 Deassertion of reset SHALL be synchronous to clk; the first grant is possible on the first edge after deassertion.

Structure
REQ-032 Package rsi_pkg SHALL hold the state encoding, RSI_MAX = 100, and the default values of NCH and W.
REQ-033 The round-robin grant logic SHALL be a separate sub-module rsi_rr_arb, inputs req/last_grant, output one-hot grant.
REQ-034 The evaluator is external; the bench SHALL model it as out1 = (RSI < 30) and out2 = (RSI > 70), delayed LAT cycles.

Verification
REQ-035 Single request: ch2 valid, rsi = 25, LAT = 2 -> ready[2] at T, res_valid at T+3, res_ch = 2, out1 = 1, out2 = 0, err = 0.
REQ-036 All four channels valid from reset with rsi = 10, 50, 80, 90 -> grants in order 0, 1, 2, 3, each 4 cycles apart; results (1,0), (0,0), (0,1), (0,1).
REQ-037 Range error: ch1 rsi = 101 -> res_valid at T+1, err = 1, out1 = out2 = 0, and the evaluator eval_rsi is unchanged.
REQ-038 Fairness: ch0 and ch3 valid continuously for 40 cycles -> grants alternate 0, 3, 0, 3 with no starvation.
REQ-039 Reset mid-WAIT: rst_n low for 1 cycle at T+1 after a grant -> no res_valid; all outputs 0; the next grant goes to ch0.
REQ-040 Boundary values: rsi = 100 is accepted without error, rsi = 0 gives out1 = 1, and LAT = 1 gives res_valid at T+2.
